vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, CPU write-buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 16, video-memory address width.
REQ-003 SHALL have port pixclk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port disp_active  in  1  display read phase (DrawArea-aligned); display owns RAM when 1.
REQ-006 SHALL have port disp_abus  in  AW  display read address (vmemabus of HDMI output stage).
REQ-007 SHALL have port disp_dbus  out  8  display read data (vmemdbus).
REQ-008 SHALL have port cpu_addr  in  AW  CPU write address.
REQ-009 SHALL have port cpu_data  in  8  CPU write data.
REQ-010 SHALL have port cpu_wr_valid  in  1  CPU write request.
REQ-011 SHALL have port cpu_wr_ready  out  1  buffer can accept a write.
REQ-012 SHALL have port fill_start  in  1  one-cycle fill request.
REQ-013 SHALL have port fill_base  in  AW  first fill address.
REQ-014 SHALL have port fill_len  in  AW  number of bytes to fill.
REQ-015 SHALL have port fill_value  in  8  fill byte.
REQ-016 SHALL have port fill_busy  out  1  fill in progress.
REQ-017 SHALL have ports ram_addr out AW, ram_wdata out 8, ram_we out 1, ram_rdata in 8: single-port video RAM.

Function
REQ-018 SHALL drive ram_addr=disp_abus, ram_we=0 combinationally whenever disp_active=1; disp_dbus=ram_rdata at all times (zero added latency).
REQ-019 SHALL accept a write when cpu_wr_valid && cpu_wr_ready; cpu_wr_ready = buffer not full.
REQ-020 SHALL, when disp_active=0 and buffer non-empty, drive oldest entry on ram_addr/ram_wdata with ram_we=1 and pop it that cycle (one write per cycle, FIFO order).
REQ-021 SHALL keep occupancy unchanged on simultaneous push and pop; push when full impossible (ready low).
REQ-022 SHALL hold all pending writes while disp_active=1; none lost, none reordered.
REQ-023 SHALL run fill FSM IDLE->FILL->IDLE: fill_start in IDLE with fill_len!=0 latches base/len/value and enters FILL; fill_busy=1 in FILL.
REQ-024 SHALL in FILL issue one write per cycle only when disp_active=0 and buffer empty (buffer has priority); address increments mod 2^AW (0xFFFF wraps to 0x0000).
REQ-025 SHALL return to IDLE the cycle after the fill_len-th write; fill_busy falls then.
REQ-026 SHALL ignore fill_start while busy and fill_start with fill_len=0 (no writes, fill_busy stays 0).
REQ-027 SHALL keep accepting CPU writes during FILL.

Reset
REQ-028 SHALL on reset empty the buffer, force FSM IDLE, fill_busy=0, ram_we=0, cpu_wr_ready=1 next cycle.
REQ-029 SHALL on reset mid-fill abort immediately; buffered writes discarded; no RAM write in the reset cycle.

Configuration
REQ-030 SHALL compile the fill engine only when VRAM_FILL_EN is defined.
REQ-031 SHALL without VRAM_FILL_EN keep all fill ports, ignore fill inputs, tie fill_busy=0; buffer behaviour identical.

Structure
REQ-032 SHALL place AW default, fill FSM state enum and RAM write-request struct (addr, data) in shared package vram_pkg.
REQ-033 SHALL implement the buffer as sub-module vram_wr_fifo (synchronous, show-ahead, count-based full/empty).

Verification
REQ-034 SHALL test: 4 writes (0x0010..0x0013, data 0xA0..0xA3) during disp_active=1 -> no ram_we, cpu_wr_ready=0 after 4th; after disp_active falls, 4 consecutive writes in order.
REQ-035 SHALL test: disp_active=1, disp_abus=0x1234, ram_rdata=0x5C -> ram_addr=0x1234, disp_dbus=0x5C same cycle.
REQ-036 SHALL test: fill_base=0xFFFE, len=4, value=0x20, disp_active=0 -> writes 0xFFFE,0xFFFF,0x0000,0x0001; fill_busy high exactly 5 cycles.
REQ-037 SHALL test: CPU write to 0x0100 arriving mid-fill -> written before next fill address; fill completes all len bytes.
REQ-038 SHALL test: reset asserted at 2nd of 8 fill writes with 2 buffered entries -> next cycle fill_busy=0, cpu_wr_ready=1, no further ram_we.
REQ-039 SHALL test: fill_start with fill_len=0, and fill_start while busy -> ignored, no extra writes.

Source files
------------

// File: rtl/vram_pkg.sv
// +------------------------------------------------------------------+
// | vram_pkg: shared types and defaults for the video-RAM arbiter.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package vram_pkg;

    localparam int VRAM_AW = 16;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1
    } fill_state_t;

    // Default-width layout of one buffered CPU write as packed into the FIFO.
    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [7:0]         data;
    } wr_req_t;

endpackage

`default_nettype wire

// File: rtl/vram_wr_fifo.sv
// +------------------------------------------------------------------+
// | vram_wr_fifo: synchronous show-ahead FIFO, count-based flags.     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = c_pw + 1;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == c_cw'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// +------------------------------------------------------------------+
// | vram_arbiter: display/CPU/fill arbitration of a single-port VRAM. |
// | Fill engine built only when VRAM_FILL_EN is defined.              |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module vram_arbiter
    import vram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = VRAM_AW
) (
    input  logic          pixclk,
    input  logic          reset,
    input  logic          disp_active,
    input  logic [AW-1:0] disp_abus,
    output logic [7:0]    disp_dbus,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_data,
    input  logic          cpu_wr_valid,
    output logic          cpu_wr_ready,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW-1:0] fill_len,
    input  logic [7:0]    fill_value,
    output logic          fill_busy,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    input  logic [7:0]    ram_rdata
);

    localparam int c_dw = AW + 8;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [c_dw-1:0] w_head;
    logic            w_fill_req;
    logic [AW-1:0]   w_fill_addr;
    logic [7:0]      w_fill_value;

    assign w_push       = cpu_wr_valid && !w_full;
    assign w_pop        = !disp_active && !w_empty && !reset;
    assign cpu_wr_ready = !w_full;
    assign disp_dbus    = ram_rdata;

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (c_dw)
    ) u_wr_fifo (
        .clk         (pixclk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data ({cpu_addr, cpu_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

`ifdef VRAM_FILL_EN
    fill_state_t   r_state;
    logic [AW-1:0] r_fill_addr;
    logic [AW-1:0] r_fill_left;
    logic [7:0]    r_fill_value;
    logic          r_fill_busy;
    logic          w_fill_go;

    // The state lingers one cycle in FILL after the last write, so busy covers len+1 cycles.
    assign w_fill_req   = (r_state == FILL_RUN) && (r_fill_left != '0);
    assign w_fill_go    = w_fill_req && !disp_active && w_empty;
    assign w_fill_addr  = r_fill_addr;
    assign w_fill_value = r_fill_value;
    assign fill_busy    = r_fill_busy;

    always_ff @(posedge pixclk) begin
        if (reset) begin
            r_state      <= FILL_IDLE;
            r_fill_busy  <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_left  <= '0;
            r_fill_value <= '0;
        end else begin
            case (r_state)
                FILL_IDLE: begin
                    if (fill_start && (fill_len != '0)) begin
                        r_fill_addr  <= fill_base;
                        r_fill_left  <= fill_len;
                        r_fill_value <= fill_value;
                        r_fill_busy  <= 1'b1;
                        r_state      <= FILL_RUN;
                    end
                end
                FILL_RUN: begin
                    if (r_fill_left == '0) begin
                        r_fill_busy <= 1'b0;
                        r_state     <= FILL_IDLE;
                    end else if (w_fill_go) begin
                        r_fill_addr <= r_fill_addr + 1'b1;
                        r_fill_left <= r_fill_left - 1'b1;
                    end
                end
                default: begin
                    r_fill_busy <= 1'b0;
                    r_state     <= FILL_IDLE;
                end
            endcase
        end
    end
`else
    logic w_fill_unused;

    assign w_fill_unused = ^{fill_start, fill_base, fill_len, fill_value};
    assign w_fill_req    = 1'b0;
    assign w_fill_addr   = '0;
    assign w_fill_value  = '0;
    assign fill_busy     = 1'b0;
`endif

    // Display owns the RAM outright; buffered CPU writes beat the fill engine.
    always_comb begin
        ram_addr  = disp_abus;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (!disp_active) begin
            if (!w_empty) begin
                ram_addr  = w_head[c_dw-1:8];
                ram_wdata = w_head[7:0];
                ram_we    = !reset;
            end else if (w_fill_req) begin
                ram_addr  = w_fill_addr;
                ram_wdata = w_fill_value;
                ram_we    = !reset;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// +------------------------------------------------------------------+
// | tb_vram_arbiter: directed self-checking bench for vram_arbiter.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_vram_arbiter;

    logic        pixclk = 1'b0;
    logic        reset;
    logic        disp_active;
    logic [15:0] disp_abus;
    logic [7:0]  disp_dbus;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic        fill_start;
    logic [15:0] fill_base;
    logic [15:0] fill_len;
    logic [7:0]  fill_value;
    logic        fill_busy;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pixclk = ~pixclk;

    vram_arbiter #(
        .FIFO_DEPTH (4),
        .AW         (16)
    ) dut (
        .pixclk       (pixclk),
        .reset        (reset),
        .disp_active  (disp_active),
        .disp_abus    (disp_abus),
        .disp_dbus    (disp_dbus),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .fill_start   (fill_start),
        .fill_base    (fill_base),
        .fill_len     (fill_len),
        .fill_value   (fill_value),
        .fill_busy    (fill_busy),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata)
    );

    task automatic clear_inputs();
        disp_active  = 1'b0;
        disp_abus    = '0;
        cpu_addr     = '0;
        cpu_data     = '0;
        cpu_wr_valid = 1'b0;
        fill_start   = 1'b0;
        fill_base    = '0;
        fill_len     = '0;
        fill_value   = '0;
        ram_rdata    = '0;
    endtask

    task automatic do_reset();
        @(negedge pixclk);
        clear_inputs();
        reset = 1'b1;
        @(negedge pixclk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge pixclk);
        clear_inputs();
        reset = 1'b1;
        #1;
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_cycle_we: got %0b want 0", ram_we);
        end
        @(negedge pixclk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (cpu_wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %0b want 1", cpu_wr_ready);
        end
        n_checks++;
        if (fill_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_fill_busy: got %0b want 0", fill_busy);
        end
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_we: got %0b want 0", ram_we);
        end
    endtask

    task automatic test_display_passthru();
        @(negedge pixclk);
        disp_active = 1'b1;
        disp_abus   = 16'h1234;
        ram_rdata   = 8'h5C;
        #1;
        n_checks++;
        if (ram_addr !== 16'h1234) begin
            n_fail++; $display("FAIL disp_addr: got %h want 1234", ram_addr);
        end
        n_checks++;
        if (disp_dbus !== 8'h5C) begin
            n_fail++; $display("FAIL disp_dbus: got %h want 5c", disp_dbus);
        end
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_fail++; $display("FAIL disp_we: got %0b want 0", ram_we);
        end
        @(negedge pixclk);
        clear_inputs();
    endtask

    task automatic test_buffer_hold();
        for (int i = 0; i < 4; i++) begin
            @(negedge pixclk);
            disp_active  = 1'b1;
            disp_abus    = 16'h0800;
            cpu_wr_valid = 1'b1;
            cpu_addr     = 16'h0010 + 16'(i);
            cpu_data     = 8'hA0 + 8'(i);
            #1;
            n_checks++;
            if (ram_we !== 1'b0 || cpu_wr_ready !== 1'b1) begin
                n_fail++; $display("FAIL hold_fill_%0d: we=%0b ready=%0b want we=0 ready=1", i, ram_we, cpu_wr_ready);
            end
        end
        // Full: this offer must be refused.
        @(negedge pixclk);
        cpu_addr = 16'h0099;
        cpu_data = 8'hEE;
        #1;
        n_checks++;
        if (cpu_wr_ready !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL hold_full: ready=%0b we=%0b want ready=0 we=0", cpu_wr_ready, ram_we);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge pixclk);
            cpu_wr_valid = 1'b0;
            disp_active  = 1'b0;
            #1;
            n_checks++;
            if (ram_we !== 1'b1 || ram_addr !== 16'h0010 + 16'(k) || ram_wdata !== 8'hA0 + 8'(k)) begin
                n_fail++; $display("FAIL drain_%0d: we=%0b addr=%h data=%h want we=1 addr=%h data=%h",
                                   k, ram_we, ram_addr, ram_wdata, 16'h0010 + 16'(k), 8'hA0 + 8'(k));
            end
        end
        @(negedge pixclk);
        #1;
        n_checks++;
        if (ram_we !== 1'b0 || cpu_wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL drain_done: we=%0b ready=%0b want we=0 ready=1", ram_we, cpu_wr_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_a [3];
        exp_a[0] = 16'h0A00; exp_a[1] = 16'h0A01; exp_a[2] = 16'h0A02;
        for (int s = 0; s < 4; s++) begin
            @(negedge pixclk);
            cpu_wr_valid = (s < 3);
            cpu_addr     = 16'h0A00 + 16'(s);
            cpu_data     = 8'h40 + 8'(s);
            #1;
            n_checks++;
            if (s == 0) begin
                if (ram_we !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_first: we=%0b want 0", ram_we);
                end
            end else if (ram_we !== 1'b1 || ram_addr !== exp_a[s-1] || ram_wdata !== 8'h40 + 8'(s-1)
                         || cpu_wr_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_%0d: we=%0b addr=%h data=%h ready=%0b want we=1 addr=%h ready=1",
                                   s, ram_we, ram_addr, ram_wdata, cpu_wr_ready, exp_a[s-1]);
            end
        end
        @(negedge pixclk);
        cpu_wr_valid = 1'b0;
        #1;
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_fail++; $display("FAIL b2b_empty: we=%0b want 0", ram_we);
        end
    endtask

`ifdef VRAM_FILL_EN
    task automatic test_fill_wrap();
        logic [15:0] exp_a [4];
        int nw = 0;
        int nb = 0;
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        @(negedge pixclk);
        fill_base  = 16'hFFFE;
        fill_len   = 16'd4;
        fill_value = 8'h20;
        fill_start = 1'b1;
        #1;
        n_checks++;
        if (fill_busy !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL wrap_start: busy=%0b we=%0b want 0 0", fill_busy, ram_we);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge pixclk);
            fill_start = 1'b0;
            #1;
            if (fill_busy === 1'b1) nb++;
            if (ram_we === 1'b1) begin
                n_checks++;
                if (nw >= 4 || ram_addr !== exp_a[nw] || ram_wdata !== 8'h20) begin
                    n_fail++; $display("FAIL wrap_write_%0d: addr=%h data=%h want addr=%h data=20",
                                       nw, ram_addr, ram_wdata, (nw < 4) ? exp_a[nw] : 16'hXXXX);
                end
                nw++;
            end
        end
        n_checks++;
        if (nw != 4) begin
            n_fail++; $display("FAIL wrap_count: got %0d writes want 4", nw);
        end
        n_checks++;
        if (nb != 5) begin
            n_fail++; $display("FAIL wrap_busy: got %0d busy cycles want 5", nb);
        end
    endtask

    task automatic test_fill_cpu_priority();
        logic [15:0] exp_a [4];
        logic [7:0]  exp_d [4];
        int nw = 0;
        exp_a[0] = 16'h0200; exp_a[1] = 16'h0201; exp_a[2] = 16'h0100; exp_a[3] = 16'h0202;
        exp_d[0] = 8'h77;    exp_d[1] = 8'h77;    exp_d[2] = 8'h55;    exp_d[3] = 8'h77;
        @(negedge pixclk);
        fill_base  = 16'h0200;
        fill_len   = 16'd3;
        fill_value = 8'h77;
        fill_start = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            @(negedge pixclk);
            fill_start   = 1'b0;
            cpu_wr_valid = (s == 2);
            cpu_addr     = 16'h0100;
            cpu_data     = 8'h55;
            #1;
            if (ram_we === 1'b1) begin
                n_checks++;
                if (nw >= 4 || ram_addr !== exp_a[nw] || ram_wdata !== exp_d[nw]) begin
                    n_fail++; $display("FAIL prio_write_%0d: addr=%h data=%h want addr=%h data=%h",
                                       nw, ram_addr, ram_wdata, (nw < 4) ? exp_a[nw] : 16'hXXXX,
                                       (nw < 4) ? exp_d[nw] : 8'hXX);
                end
                nw++;
            end
        end
        n_checks++;
        if (nw != 4 || fill_busy !== 1'b0) begin
            n_fail++; $display("FAIL prio_count: writes=%0d busy=%0b want writes=4 busy=0", nw, fill_busy);
        end
    endtask

    task automatic test_fill_reset();
        int stray = 0;
        @(negedge pixclk);
        fill_base  = 16'h0300;
        fill_len   = 16'd8;
        fill_value = 8'h11;
        fill_start = 1'b1;
        @(negedge pixclk);
        fill_start = 1'b0;
        #1;
        n_checks++;
        if (ram_we !== 1'b1 || ram_addr !== 16'h0300) begin
            n_fail++; $display("FAIL freset_first: we=%0b addr=%h want we=1 addr=0300", ram_we, ram_addr);
        end
        for (int s = 0; s < 2; s++) begin
            @(negedge pixclk);
            disp_active  = 1'b1;
            cpu_wr_valid = 1'b1;
            cpu_addr     = 16'h00A0 + 16'(s);
            cpu_data     = 8'h01;
        end
        @(negedge pixclk);
        disp_active  = 1'b0;
        cpu_wr_valid = 1'b0;
        reset        = 1'b1;
        #1;
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_fail++; $display("FAIL freset_cycle_we: we=%0b want 0", ram_we);
        end
        @(negedge pixclk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (fill_busy !== 1'b0 || cpu_wr_ready !== 1'b1 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL freset_after: busy=%0b ready=%0b we=%0b want 0 1 0",
                               fill_busy, cpu_wr_ready, ram_we);
        end
        for (int s = 0; s < 10; s++) begin
            @(negedge pixclk);
            #1;
            if (ram_we === 1'b1) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++; $display("FAIL freset_stray: got %0d writes want 0", stray);
        end
    endtask

    task automatic test_fill_ignore();
        int bad = 0;
        int nw  = 0;
        int nb  = 0;
        @(negedge pixclk);
        fill_base  = 16'h0400;
        fill_len   = 16'd0;
        fill_value = 8'h33;
        fill_start = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge pixclk);
            fill_start = 1'b0;
            #1;
            if (fill_busy !== 1'b0 || ram_we !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL ignore_len0: %0d cycles active want 0", bad);
        end
        @(negedge pixclk);
        fill_len   = 16'd2;
        fill_start = 1'b1;
        for (int s = 0; s < 8; s++) begin
            @(negedge pixclk);
            fill_start = (s == 0);
            fill_base  = 16'h0500;
            fill_len   = 16'd5;
            #1;
            if (fill_busy === 1'b1) nb++;
            if (ram_we === 1'b1) begin
                n_checks++;
                if (ram_addr !== 16'h0400 + 16'(nw) || nw >= 2) begin
                    n_fail++; $display("FAIL ignore_write_%0d: addr=%h want %h", nw, ram_addr, 16'h0400 + 16'(nw));
                end
                nw++;
            end
        end
        n_checks++;
        if (nw != 2 || nb != 3) begin
            n_fail++; $display("FAIL ignore_busy: writes=%0d busy=%0d want writes=2 busy=3", nw, nb);
        end
    endtask
`else
    task automatic test_fill_disabled();
        int bad = 0;
        @(negedge pixclk);
        fill_base  = 16'h0400;
        fill_len   = 16'd4;
        fill_value = 8'h33;
        fill_start = 1'b1;
        for (int s = 0; s < 6; s++) begin
            #1;
            if (fill_busy !== 1'b0 || ram_we !== 1'b0) bad++;
            @(negedge pixclk);
            fill_start = 1'b0;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL fill_disabled: %0d active cycles want 0", bad);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_display_passthru();
        do_reset();
        test_buffer_hold();
        do_reset();
        test_back_to_back();
`ifdef VRAM_FILL_EN
        do_reset();
        test_fill_wrap();
        do_reset();
        test_fill_cpu_priority();
        do_reset();
        test_fill_reset();
        do_reset();
        test_fill_ignore();
`else
        do_reset();
        test_fill_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
